bit_deser: RTL and testbench
============================

BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the parallel word width (legal range 2..32).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1; 1 = first serial bit lands in pout[WIDTH-1], 0 = first bit lands in pout[0].
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The module SHALL have port sin, input, 1, the serial data bit.
REQ-006 The module SHALL have port sin_valid, input, 1; sin is meaningful this cycle.
REQ-007 The module SHALL have port sin_start, input, 1; qualified by sin_valid, marks the first bit of a frame.
REQ-008 The module SHALL have port sin_ready, output, 1; a bit is accepted only when sin_valid && sin_ready.
REQ-009 The module SHALL have port pout, output, WIDTH, the assembled word.
REQ-010 The module SHALL have port pout_valid, output, 1; pout holds a complete word.
REQ-011 The module SHALL have port pout_ready, input, 1; the consumer takes the word when pout_valid && pout_ready.
REQ-012 The module SHALL have port framing_err, output, 1, a one-cycle pulse on a restarted frame.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PAR (parity build only) and HOLD.
REQ-014 In IDLE, an accepted bit with sin_start=1 SHALL be stored as bit 1 of the frame and move the FSM to SHIFT; accepted bits with sin_start=0 SHALL be discarded.
REQ-015 In SHIFT, each accepted bit SHALL be stored at the next position per MSB_FIRST and the bit counter incremented; cycles without sin_valid hold state.
REQ-016 Acceptance of bit WIDTH SHALL move the FSM to HOLD, or to PAR when parity is compiled in; pout_valid SHALL be 1 in the cycle after that edge (latency 1).
REQ-017 An accepted bit with sin_start=1 while in SHIFT or PAR SHALL discard the partial frame, restart with that bit as bit 1, and pulse framing_err for one cycle.
REQ-018 In HOLD, pout and pout_valid SHALL remain stable until pout_ready=1.
REQ-019 sin_ready SHALL equal (state != HOLD) || pout_ready.
REQ-020 In HOLD, when pout_ready=1 and an accepted bit with sin_start=1 arrive in the same cycle, the word SHALL be consumed and the new frame started in SHIFT with no lost bit.
REQ-021 In HOLD, when pout_ready=1 with no new frame start, the FSM SHALL return to IDLE and drop pout_valid next cycle.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap; it clears on every frame start.
REQ-023 pout SHALL only update on the transition into HOLD; it SHALL never show a partial word.

Reset
REQ-024 With rst_n=0, asynchronously: state=IDLE, counter=0, pout=0, pout_valid=0, framing_err=0, parity_err=0, sin_ready=1.
REQ-025 Reset asserted mid-frame or in HOLD SHALL drop the frame or word with no pulse on any output.
REQ-026 Deassertion SHALL take effect on the first rising clk edge after rst_n rises.

Configuration
REQ-027 With macro BIT_DESER_PARITY_EN defined, each frame SHALL carry one extra even-parity bit after the WIDTH data bits; PAR accepts it, then HOLD; output parity_err (1 bit) SHALL be valid with pout_valid and be 1 when the XOR of the data and parity bits is 1.
REQ-028 With the macro undefined, state PAR and port parity_err SHALL be absent and frames SHALL be exactly WIDTH bits long.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, bits 1,0,0,1,0,1,1,0 on consecutive cycles (start on first) -> pout=8'h96 and pout_valid=1 on the cycle after the 8th bit.
REQ-030 WIDTH=8, MSB_FIRST=0, the same bit stream -> pout=8'h69.
REQ-031 pout_ready held 0 for 5 cycles in HOLD with sin_valid=1 -> sin_ready=0, pout stays 8'h96, and no bit is accepted.
REQ-032 New sin_start after 3 bits of a frame -> framing_err=1 for one cycle, and the next 8 bits yield a correct word.
REQ-033 Consume plus new sin_start in the same cycle -> second word correct, no idle cycle, no lost bit.
REQ-034 BIT_DESER_PARITY_EN defined, data 8'h96 followed by parity 0 -> parity_err=0; with parity 1 -> parity_err=1; rst_n pulse mid-frame -> all outputs return to their reset values.

Source files
------------

// File: rtl/bit_deser.sv
// bit_deser: serial-to-parallel deserializer with frame start and ready/valid handshake.
//
// A frame begins with an accepted bit carrying sin_start and runs for WIDTH data bits.
// The word is presented on pout/pout_valid and held until the consumer takes it.
// A sin_start in the middle of a frame abandons the partial word and restarts.
//
// Parameters:
//   WIDTH     - parallel word width (2..32)
//   MSB_FIRST - 1: first serial bit lands in pout[WIDTH-1]; 0: first bit lands in pout[0]
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sin         in   serial data bit
//   sin_valid   in   sin is meaningful this cycle
//   sin_start   in   first bit of a frame (qualified by sin_valid)
//   sin_ready   out  a bit is accepted when sin_valid && sin_ready
//   pout        out  assembled word
//   pout_valid  out  pout holds a complete word
//   pout_ready  in   consumer takes the word when pout_valid && pout_ready
//   parity_err  out  even-parity failure, valid with pout_valid (BIT_DESER_PARITY_EN only)
//   framing_err out  one-cycle pulse when a frame is restarted
//
// Build option: define BIT_DESER_PARITY_EN to append one even-parity bit to every frame.
module bit_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic             sin_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
`ifdef BIT_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             framing_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef BIT_DESER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             ferr_q, ferr_d;
  logic             accept;
  logic             load_first;
  logic [WIDTH-1:0] shifted;
`ifdef BIT_DESER_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  assign sin_ready = (state_q != StHold) || pout_ready;
  assign accept    = sin_valid && sin_ready;

  // After WIDTH shifts the first bit sits at the MSB (MSB_FIRST) or the LSB.
  assign shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    pout_d     = pout_q;
    ferr_d     = 1'b0;
    load_first = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept && sin_start) load_first = 1'b1;
      end
      StShift: begin
        if (accept) begin
          if (sin_start) begin
            load_first = 1'b1;
            ferr_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            sh_d  = shifted;
`ifdef BIT_DESER_PARITY_EN
            par_d = par_q ^ sin;
            if (cnt_q == CW'(WIDTH - 1)) state_d = StPar;
`else
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_d = StHold;
              pout_d  = shifted;
            end
`endif
          end
        end
      end
`ifdef BIT_DESER_PARITY_EN
      StPar: begin
        if (accept) begin
          if (sin_start) begin
            load_first = 1'b1;
            ferr_d     = 1'b1;
          end else begin
            state_d = StHold;
            pout_d  = sh_q;
            perr_d  = par_q ^ sin;
          end
        end
      end
`endif
      StHold: begin
        if (pout_ready) begin
          // Word consumed; a simultaneous start bit opens the next frame directly.
          if (accept && sin_start) begin
            load_first = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
`ifdef BIT_DESER_PARITY_EN
          perr_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_first) begin
      state_d = StShift;
      cnt_d   = CW'(1);
      sh_d    = shifted;
`ifdef BIT_DESER_PARITY_EN
      par_d   = sin;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      pout_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pout_q  <= pout_d;
      ferr_q  <= ferr_d;
`ifdef BIT_DESER_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign pout        = pout_q;
  assign pout_valid  = (state_q == StHold);
  assign framing_err = ferr_q;
`ifdef BIT_DESER_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_bit_deser.sv
// tb_bit_deser: directed bench for bit_deser. Two instances share the serial stimulus,
// one MSB-first and one LSB-first, so every frame checks both bit orders.
module tb_bit_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_start = 1'b0;
  logic       pout_ready = 1'b0;
  logic       sin_ready_m, sin_ready_l;
  logic       pout_valid_m, pout_valid_l;
  logic       ferr_m, ferr_l;
  logic [7:0] pout_m, pout_l;
`ifdef BIT_DESER_PARITY_EN
  logic       perr_m, perr_l;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .sin_ready  (sin_ready_m),
    .pout       (pout_m),
    .pout_valid (pout_valid_m),
    .pout_ready (pout_ready),
`ifdef BIT_DESER_PARITY_EN
    .parity_err (perr_m),
`endif
    .framing_err(ferr_m)
  );

  bit_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .sin_ready  (sin_ready_l),
    .pout       (pout_l),
    .pout_valid (pout_valid_l),
    .pout_ready (pout_ready),
`ifdef BIT_DESER_PARITY_EN
    .parity_err (perr_l),
`endif
    .framing_err(ferr_l)
  );

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic drive(input logic b, input logic v, input logic s, input logic r);
    sin = b; sin_valid = v; sin_start = s; pout_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Send a full frame MSB of w first, with correct parity when parity is built in.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive(w[i], 1'b1, (i == 7), 1'b0);
`ifdef BIT_DESER_PARITY_EN
    drive(^w, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #10;
    n_checks++; if (pout_m !== 8'h00) begin n_fail++; $display("FAIL reset_pout: got %h want 00", pout_m); end
    n_checks++; if (pout_valid_m !== 1'b0 || pout_valid_l !== 1'b0) begin n_fail++; $display("FAIL reset_pout_valid: got %b%b want 00", pout_valid_m, pout_valid_l); end
    n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err: got %b want 0", ferr_m); end
    n_checks++; if (sin_ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_sin_ready: got %b want 1", sin_ready_m); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pout_valid_m !== 1'b0 || sin_ready_m !== 1'b1) begin n_fail++; $display("FAIL post_reset: got valid=%b ready=%b want 0 1", pout_valid_m, sin_ready_m); end
  endtask

  task automatic test_msb_lsb;
    logic [7:0] w;
    w = 8'h96;
    for (int i = 7; i >= 1; i--) drive(w[i], 1'b1, (i == 7), 1'b0);
    n_checks++; if (pout_valid_m !== 1'b0 || pout_m !== 8'h00) begin n_fail++; $display("FAIL partial_word: got valid=%b pout=%h want 0 00", pout_valid_m, pout_m); end
    drive(w[0], 1'b1, 1'b0, 1'b0);
`ifdef BIT_DESER_PARITY_EN
    n_checks++; if (pout_valid_m !== 1'b0) begin n_fail++; $display("FAIL valid_before_parity: got %b want 0", pout_valid_m); end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (perr_m !== 1'b0) begin n_fail++; $display("FAIL parity_ok: got %b want 0", perr_m); end
`endif
    n_checks++; if (pout_valid_m !== 1'b1) begin n_fail++; $display("FAIL msb_valid: got %b want 1", pout_valid_m); end
    n_checks++; if (pout_m !== 8'h96) begin n_fail++; $display("FAIL msb_word: got %h want 96", pout_m); end
    n_checks++; if (pout_l !== 8'h69) begin n_fail++; $display("FAIL lsb_word: got %h want 69", pout_l); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++; if (sin_ready_m !== 1'b0) begin n_fail++; $display("FAIL hold_sin_ready[%0d]: got %b want 0", i, sin_ready_m); end
      n_checks++; if (pout_m !== 8'h96 || pout_valid_m !== 1'b1) begin n_fail++; $display("FAIL hold_word[%0d]: got %h/%b want 96/1", i, pout_m, pout_valid_m); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (pout_valid_m !== 1'b0 || sin_ready_m !== 1'b1) begin n_fail++; $display("FAIL consume: got valid=%b ready=%b want 0 1", pout_valid_m, sin_ready_m); end
    n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL hold_no_ferr: got %b want 0", ferr_m); end
  endtask

  task automatic test_framing;
    logic [7:0] w;
    w = 8'hC5;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL ferr_before_restart: got %b want 0", ferr_m); end
    drive(w[7], 1'b1, 1'b1, 1'b0);
    n_checks++; if (ferr_m !== 1'b1 || ferr_l !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %b%b want 11", ferr_m, ferr_l); end
    drive(w[6], 1'b1, 1'b0, 1'b0);
    n_checks++; if (ferr_m !== 1'b0) begin n_fail++; $display("FAIL ferr_one_cycle: got %b want 0", ferr_m); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 5; i >= 0; i--) drive(w[i], 1'b1, 1'b0, 1'b0);
`ifdef BIT_DESER_PARITY_EN
    drive(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    n_checks++; if (pout_valid_m !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b want 1", pout_valid_m); end
    n_checks++; if (pout_m !== 8'hC5) begin n_fail++; $display("FAIL restart_msb_word: got %h want c5", pout_m); end
    n_checks++; if (pout_l !== 8'hA3) begin n_fail++; $display("FAIL restart_lsb_word: got %h want a3", pout_l); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    w = 8'h3A;
    drive(w[7], 1'b1, 1'b1, 1'b1);
    n_checks++; if (pout_valid_m !== 1'b0 || ferr_m !== 1'b0) begin n_fail++; $display("FAIL b2b_consume: got valid=%b ferr=%b want 0 0", pout_valid_m, ferr_m); end
    n_checks++; if (pout_m !== 8'hC5) begin n_fail++; $display("FAIL b2b_old_word_kept: got %h want c5", pout_m); end
    for (int i = 6; i >= 0; i--) drive(w[i], 1'b1, 1'b0, 1'b0);
`ifdef BIT_DESER_PARITY_EN
    drive(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    n_checks++; if (pout_valid_m !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", pout_valid_m); end
    n_checks++; if (pout_m !== 8'h3A) begin n_fail++; $display("FAIL b2b_msb_word: got %h want 3a", pout_m); end
    n_checks++; if (pout_l !== 8'h5C) begin n_fail++; $display("FAIL b2b_lsb_word: got %h want 5c", pout_l); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef BIT_DESER_PARITY_EN
  task automatic test_parity;
    logic [7:0] w;
    w = 8'h96;
    for (int i = 7; i >= 0; i--) drive(w[i], 1'b1, (i == 7), 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (perr_m !== 1'b1 || perr_l !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b%b want 11", perr_m, perr_l); end
    n_checks++; if (pout_m !== 8'h96 || pout_valid_m !== 1'b1) begin n_fail++; $display("FAIL parity_word: got %h/%b want 96/1", pout_m, pout_valid_m); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (pout_m !== 8'h00 || pout_l !== 8'h00) begin n_fail++; $display("FAIL mid_reset_pout: got %h/%h want 00/00", pout_m, pout_l); end
    n_checks++; if (pout_valid_m !== 1'b0 || ferr_m !== 1'b0 || sin_ready_m !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ctrl: got v=%b f=%b r=%b want 0 0 1", pout_valid_m, ferr_m, sin_ready_m); end
`ifdef BIT_DESER_PARITY_EN
    n_checks++; if (perr_m !== 1'b0) begin n_fail++; $display("FAIL mid_reset_perr: got %b want 0", perr_m); end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (pout_valid_m !== 1'b0 || ferr_m !== 1'b0) begin n_fail++; $display("FAIL after_reset_idle: got v=%b f=%b want 0 0", pout_valid_m, ferr_m); end
    send_word(8'h12);
    n_checks++; if (pout_m !== 8'h12 || pout_l !== 8'h48) begin n_fail++; $display("FAIL after_reset_word: got %h/%h want 12/48", pout_m, pout_l); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pout_valid_m !== 1'b0 || pout_m !== 8'h00 || sin_ready_m !== 1'b1) begin n_fail++; $display("FAIL hold_reset: got v=%b pout=%h r=%b want 0 00 1", pout_valid_m, pout_m, sin_ready_m); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_hold();
    test_framing();
    test_back_to_back();
`ifdef BIT_DESER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
